// File: rtl/led_scan.sv
// -----------------------------------------------------------------------------
// led_scan
// Row-multiplexed driver for a 16x16 LED matrix showing CPU state.
// Rows 0-7 show register-file words r0..r7 and rows 8-15 show datapath words
// (pc, ir, sr1, sr2, alu, dr, 0, 0). Each row is lit for one slot of DIV
// cycles. The first BLANK cycles of every slot drive the columns dark so
// that ghosting from the previous row is hidden.
// The column data always comes from a 256-bit snapshot. The snapshot is
// reloaded once per frame, so a frame never mixes old and new values.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset; restarts the scan at slot 0
//   led_reg     {r7..r0}, 16 bits per register
//   led_misc    {0,0,dr,alu,sr2,sr1,ir,pc}
//   led_ph      one-hot CPU phase
//   freeze      high in the last cycle of a frame keeps the current snapshot
//   row         one-hot row drive, active-high
//   col         column data for the lit row, active-high
//   ph_out      led_ph delayed by one cycle
//   frame_start high on the first cycle of each frame
// -----------------------------------------------------------------------------
module led_scan #(
    parameter int DIV   = 1000,
    parameter int BLANK = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] led_reg,
    input  logic [127:0] led_misc,
    input  logic [3:0]   led_ph,
    input  logic         freeze,
    output logic [15:0]  row,
    output logic [15:0]  col,
    output logic [3:0]   ph_out,
    output logic         frame_start
);

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

    logic [15:0]  cnt;
    logic [3:0]   row_idx;
    logic [255:0] snap;
    logic         slot_end;
    logic         frame_end;
    logic         blank;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (row_idx == 4'd15);

    // Slot counter and row index. row_idx wraps naturally from 15 to 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            row_idx <= '0;
        end else if (slot_end) begin
            cnt     <= '0;
            row_idx <= row_idx + 4'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Snapshot: loaded during reset, so the first frame is valid. Otherwise it
    // is reloaded only in the last cycle of a frame, and only while not frozen.
    always_ff @(posedge CLK) begin
        if (RST || (frame_end && !freeze)) begin
            snap <= {led_misc, led_reg};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_out <= '0;
        end else begin
            ph_out <= led_ph;
        end
    end

    // Blanking compare is elided when BLANK is 0, so no constant-false compare
    // is left in the netlist.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            localparam logic [15:0] BLANK_LEN = 16'(BLANK);
            assign blank = (cnt < BLANK_LEN);
        end
    endgenerate

    // All outputs decode registered state only.
    assign row         = 16'd1 << row_idx;
    assign col         = blank ? 16'h0000 : snap[{row_idx, 4'b0000} +: 16];
    assign frame_start = (row_idx == 4'd0) && (cnt == 16'd0);

endmodule

// File: tb/tb_led_scan.sv
// -----------------------------------------------------------------------------
// tb_led_scan
// Bench for led_scan. It runs two instances side by side on shared inputs:
//   dut_a  DIV=4, BLANK=1
//   dut_b  DIV=2, BLANK=0
// Each expected output is queued with the cycle (counted from reset release)
// in which it must appear. The checker pops and compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_led_scan;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] led_reg;
    logic [127:0] led_misc;
    logic [3:0]   led_ph;
    logic         freeze;

    logic [15:0]  a_row, a_col, b_row, b_col;
    logic [3:0]   a_ph, b_ph;
    logic         a_fs, b_fs;

    always #5 CLK = ~CLK;

    led_scan #(.DIV(4), .BLANK(1)) dut_a (
        .CLK(CLK), .RST(RST), .led_reg(led_reg), .led_misc(led_misc),
        .led_ph(led_ph), .freeze(freeze),
        .row(a_row), .col(a_col), .ph_out(a_ph), .frame_start(a_fs)
    );

    led_scan #(.DIV(2), .BLANK(0)) dut_b (
        .CLK(CLK), .RST(RST), .led_reg(led_reg), .led_misc(led_misc),
        .led_ph(led_ph), .freeze(freeze),
        .row(b_row), .col(b_col), .ph_out(b_ph), .frame_start(b_fs)
    );

    // mask bits: 0 row, 1 col, 2 frame_start, 3 ph_out
    typedef struct {
        int          cyc;
        bit          dut;
        logic [15:0] row;
        logic [15:0] col;
        logic        fs;
        logic [3:0]  ph;
        logic [3:0]  mask;
        string       name;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] row;
        logic [15:0] col;
        logic        fs;
    } vec_t;

    exp_t sb[$];
    exp_t chk_e;
    vec_t basic[14];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   flush  = 1'b0;

    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [127:0] ramp();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'h1111 * 16'(i);
        return v;
    endfunction

    function automatic logic [127:0] fill(input logic [15:0] w);
        return {8{w}};
    endfunction

    function automatic void push_exp(input int c, input bit d, input logic [15:0] r,
                                     input logic [15:0] cl, input logic f,
                                     input logic [3:0] p, input logic [3:0] m,
                                     input string n);
        exp_t e;
        int   idx;
        e   = '{c, d, r, cl, f, p, m, n};
        idx = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].cyc > c) begin
                idx = k;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    task automatic compare_out(input exp_t e);
        logic [15:0] r, cl;
        logic        f;
        logic [3:0]  p;
        r  = e.dut ? b_row : a_row;
        cl = e.dut ? b_col : a_col;
        f  = e.dut ? b_fs  : a_fs;
        p  = e.dut ? b_ph  : a_ph;
        if (e.mask[0]) begin
            checks++;
            if (r !== e.row) begin
                errors++;
                $display("FAIL %s row cyc=%0d dut=%0d: got %h want %h", e.name, e.cyc, e.dut, r, e.row);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (cl !== e.col) begin
                errors++;
                $display("FAIL %s col cyc=%0d dut=%0d: got %h want %h", e.name, e.cyc, e.dut, cl, e.col);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (f !== e.fs) begin
                errors++;
                $display("FAIL %s frame_start cyc=%0d dut=%0d: got %b want %b", e.name, e.cyc, e.dut, f, e.fs);
            end
        end
        if (e.mask[3]) begin
            checks++;
            if (p !== e.ph) begin
                errors++;
                $display("FAIL %s ph_out cyc=%0d dut=%0d: got %b want %b", e.name, e.cyc, e.dut, p, e.ph);
            end
        end
    endtask

    // Scoreboard checker, sampling on the falling edge.
    always @(negedge CLK) begin
        if (flush) begin
            while (sb.size() > 0) begin
                chk_e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: cycle %0d never checked (now %0d)", chk_e.name, chk_e.cyc, cyc);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk_e = sb.pop_front();
            if (chk_e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: cycle %0d missed (now %0d)", chk_e.name, chk_e.cyc, cyc);
            end else begin
                compare_out(chk_e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic go_to(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 5000) begin
            tick(1);
            g++;
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 1000) begin
            tick(1);
            g++;
        end
    endtask

    task automatic do_reset(input logic [127:0] r, input logic [127:0] m, input logic [3:0] p);
        wait_drain();
        RST      = 1'b1;
        led_reg  = r;
        led_misc = m;
        led_ph   = p;
        freeze   = 1'b0;
        tick(2);
        RST = 1'b0;
    endtask

    initial begin
        basic[0]  = '{0,   16'h0001, 16'h0000, 1'b1};
        basic[1]  = '{1,   16'h0001, 16'h0000, 1'b0};
        basic[2]  = '{4,   16'h0002, 16'h0000, 1'b0};
        basic[3]  = '{5,   16'h0002, 16'h1111, 1'b0};
        basic[4]  = '{7,   16'h0002, 16'h1111, 1'b0};
        basic[5]  = '{8,   16'h0004, 16'h0000, 1'b0};
        basic[6]  = '{9,   16'h0004, 16'h2222, 1'b0};
        basic[7]  = '{31,  16'h0080, 16'h7777, 1'b0};
        basic[8]  = '{32,  16'h0100, 16'h0000, 1'b0};
        basic[9]  = '{33,  16'h0100, 16'h0000, 1'b0};
        basic[10] = '{63,  16'h8000, 16'h0000, 1'b0};
        basic[11] = '{64,  16'h0001, 16'h0000, 1'b1};
        basic[12] = '{69,  16'h0002, 16'h1111, 1'b0};
        basic[13] = '{128, 16'h0001, 16'h0000, 1'b1};

        RST = 1'b1; led_reg = '0; led_misc = '0; led_ph = '0; freeze = 1'b0;
        tick(1);

        // Basic scan
        do_reset(ramp(), '0, 4'b0001);
        for (int k = 0; k < 14; k++)
            push_exp(basic[k].cyc, 1'b0, basic[k].row, basic[k].col, basic[k].fs, 4'h0, 4'b0111,
                     $sformatf("basic%0d", k));
        push_exp(0, 1'b0, '0, '0, 1'b0, 4'b0000, 4'b1000, "ph_reset");
        push_exp(1, 1'b0, '0, '0, 1'b0, 4'b0001, 4'b1000, "ph_first");
        for (int c = 0; c < 32; c++) begin
            int s;
            s = (c / 2) % 16;
            push_exp(c, 1'b1, 16'd1 << s, (s < 8) ? 16'h1111 * 16'(s) : 16'h0000, c == 0,
                     4'h0, 4'b0111, $sformatf("b_scan%0d", c));
        end
        go_to(129);

        // Snapshot consistency
        do_reset(ramp(), '0, 4'b0001);
        push_exp(17, 1'b0, 16'h0010, 16'h4444, 1'b0, 4'h0, 4'b0011, "snap_r4");
        push_exp(21, 1'b0, 16'h0020, 16'h5555, 1'b0, 4'h0, 4'b0011, "snap_r5");
        push_exp(25, 1'b0, 16'h0040, 16'h6666, 1'b0, 4'h0, 4'b0011, "snap_r6");
        push_exp(29, 1'b0, 16'h0080, 16'h7777, 1'b0, 4'h0, 4'b0011, "snap_r7");
        push_exp(65, 1'b0, 16'h0001, 16'hFFFF, 1'b0, 4'h0, 4'b0011, "snap_new_r0");
        push_exp(69, 1'b0, 16'h0002, 16'hFFFF, 1'b0, 4'h0, 4'b0011, "snap_new_r1");
        push_exp(93, 1'b0, 16'h0080, 16'hFFFF, 1'b0, 4'h0, 4'b0011, "snap_new_r7");
        push_exp(97, 1'b0, 16'h0100, 16'h0000, 1'b0, 4'h0, 4'b0011, "snap_new_r8");
        for (int c = 32; c < 48; c++)
            push_exp(c, 1'b1, 16'd1 << ((c - 32) / 2), 16'hFFFF, c == 32, 4'h0, 4'b0111,
                     $sformatf("b_noblank%0d", c));
        go_to(12);
        led_reg = fill(16'hFFFF);
        go_to(98);

        // Freeze across one frame boundary
        do_reset(ramp(), '0, 4'b0001);
        push_exp(64,  1'b0, 16'h0001, 16'h0000, 1'b1, 4'h0, 4'b0111, "frz_fs");
        push_exp(69,  1'b0, 16'h0002, 16'h1111, 1'b0, 4'h0, 4'b0111, "frz_hold_r1");
        push_exp(93,  1'b0, 16'h0080, 16'h7777, 1'b0, 4'h0, 4'b0111, "frz_hold_r7");
        push_exp(96,  1'b0, 16'h0100, 16'h0000, 1'b0, 4'h0, 4'b0111, "frz_scan_r8");
        push_exp(128, 1'b0, 16'h0001, 16'h0000, 1'b1, 4'h0, 4'b0111, "unfrz_fs");
        push_exp(129, 1'b0, 16'h0001, 16'hFFFF, 1'b0, 4'h0, 4'b0111, "unfrz_r0");
        push_exp(133, 1'b0, 16'h0002, 16'hFFFF, 1'b0, 4'h0, 4'b0111, "unfrz_r1");
        go_to(40);
        led_reg = fill(16'hFFFF);
        freeze  = 1'b1;
        go_to(100);
        freeze = 1'b0;
        go_to(134);

        // Reset mid-frame at row 9, cnt 2, with freeze high in the reset cycle
        do_reset(ramp(), '0, 4'b0001);
        push_exp(37, 1'b0, 16'h0200, 16'h0000, 1'b0, 4'h0, 4'b0111, "pre_rst37");
        push_exp(38, 1'b0, 16'h0200, 16'h0000, 1'b0, 4'h0, 4'b0111, "pre_rst38");
        go_to(38);
        RST      = 1'b1;
        freeze   = 1'b1;
        led_reg  = fill(16'h5A5A);
        for (int j = 0; j < 8; j++) led_misc[16*j +: 16] = 16'hA000 + 16'(j);
        led_ph   = 4'b0100;
        tick(1);
        RST      = 1'b0;
        freeze   = 1'b0;
        led_reg  = ramp();
        led_misc = '0;
        push_exp(0,  1'b0, 16'h0001, 16'h0000, 1'b1, 4'b0000, 4'b1111, "rst_mid_c0");
        push_exp(1,  1'b0, 16'h0001, 16'h5A5A, 1'b0, 4'b0100, 4'b1111, "rst_mid_c1");
        push_exp(29, 1'b0, 16'h0080, 16'h5A5A, 1'b0, 4'h0, 4'b0111, "rst_snap_r7");
        push_exp(33, 1'b0, 16'h0100, 16'hA000, 1'b0, 4'h0, 4'b0111, "rst_snap_r8");
        push_exp(37, 1'b0, 16'h0200, 16'hA001, 1'b0, 4'h0, 4'b0111, "rst_snap_r9");
        push_exp(61, 1'b0, 16'h8000, 16'hA007, 1'b0, 4'h0, 4'b0111, "rst_snap_r15");
        push_exp(65, 1'b0, 16'h0001, 16'h0000, 1'b0, 4'h0, 4'b0111, "post_rst_r0");
        push_exp(69, 1'b0, 16'h0002, 16'h1111, 1'b0, 4'h0, 4'b0111, "post_rst_r1");
        push_exp(97, 1'b0, 16'h0100, 16'h0000, 1'b0, 4'h0, 4'b0111, "post_rst_r8");

        // ph_out tracking
        push_exp(100, 1'b0, '0, '0, 1'b0, 4'b0100, 4'b1000, "ph_c100");
        push_exp(101, 1'b0, '0, '0, 1'b0, 4'b0001, 4'b1000, "ph_c101");
        push_exp(102, 1'b0, '0, '0, 1'b0, 4'b0010, 4'b1000, "ph_c102");
        push_exp(103, 1'b0, '0, '0, 1'b0, 4'b0100, 4'b1000, "ph_c103");
        push_exp(104, 1'b0, '0, '0, 1'b0, 4'b1000, 4'b1000, "ph_c104");
        push_exp(104, 1'b1, '0, '0, 1'b0, 4'b1000, 4'b1000, "ph_b_c104");
        go_to(100);
        led_ph = 4'b0001;
        tick(1);
        led_ph = 4'b0010;
        tick(1);
        led_ph = 4'b0100;
        tick(1);
        led_ph = 4'b1000;
        tick(1);
        go_to(106);

        wait_drain();
        flush = 1'b1;
        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
